flash_prog_core: RTL
====================

# flash_prog_core

Write-direction companion to the read-only flash core: issues AMD/CFI-style command sequences (word program, sector erase, chip erase, read-array reset) to the parallel NOR flash and waits on RY/BY# for completion. It sits between a bus-side request port and the flash pins. Pin sharing with the read core is done by an external mux and is not part of this block. Write cycles are WE#-controlled; OE# is never asserted.

## Interface
- CLK_FREQ, 100, main clock frequency in MHz
- ADDR_BITS, 24, flash address length (word address bits ADDR_BITS-1:1)
- TIMEOUT_US, 4000000, max busy wait in µs before an error is flagged
- clk  in  1  main clock
- rst_n  in  1  reset, asynchronous, active-low
- cs  in  1  request strobe, sampled only in S_IDLE
- op  in  2  0 RESET (F0), 1 PROGRAM, 2 SECTOR_ERASE, 3 CHIP_ERASE
- addr  in  ADDR_BITS-1  word address (program target / sector address)
- din  in  16  program data
- busy  out  1  block not idle
- ack  out  1  one-cycle completion pulse
- err  out  1  valid with ack; 1 = busy timeout
- flash_ce_n, flash_oe_n, flash_we_n, flash_wp_n, flash_rst_n  out  1 each  flash controls
- flash_ready  in  1  RY/BY#, 1 = ready
- flash_addr  out  ADDR_BITS-1  flash address
- flash_din  in  16  unused (reserved for status polling)
- flash_dout  out  16  flash write data

## Operation
- Reset (rst_n low, async): ce_n=1, oe_n=1, we_n=1, wp_n=0, flash_rst_n=0, flash_addr=0, flash_dout=0, busy=0, ack=0, err=0, state S_INIT, counters 0. Asserting rst_n mid-operation aborts immediately. flash_rst_n low also aborts the flash's embedded algorithm.
- flash_rst_n rises on the first clk edge after rst_n release.
- Timing counts: COUNT_x = 1 + CLK_FREQ*DELAY_x/1000, with DELAY_INIT=300000, DELAY_WP=50, DELAY_WPH=30, DELAY_BUSY=500 (ns). At 100 MHz this gives 30001, 6, 4, 51.
- S_INIT: busy=1; count to COUNT_INIT-1, then hold there until flash_ready=1; then go to S_IDLE.
- S_IDLE: busy=0. On cs=1, latch op/addr/din, set seq index to 0, go to S_SETUP.
- S_SETUP (1 cycle): ce_n=0, we_n=1, wp_n=1; flash_addr/flash_dout = command-table entry.
- S_PULSE (COUNT_WP cycles): we_n=0; address and data held.
- S_HOLD (COUNT_WPH cycles): we_n=1, ce_n=1; address and data held. Then:
  - if not the last entry: index+1, go to S_SETUP;
  - else if op=RESET: go to S_DONE;
  - else: go to S_BUSY.
- Command table (word addresses, data):
  - RESET: (addr, F0)
  - PROGRAM: (555,AA) (2AA,55) (555,A0) (addr,din)
  - SECTOR_ERASE: (555,AA) (2AA,55) (555,80) (555,AA) (2AA,55) (addr,30)
  - CHIP_ERASE: same as SECTOR_ERASE with last entry (555,10)
- S_BUSY: wp_n=1, all strobes inactive.
  - Ignore flash_ready for COUNT_BUSY cycles (tBUSY).
  - Then go to S_DONE on the first cycle with flash_ready=1.
  - A 1 µs prescaler drives a µs counter; reaching TIMEOUT_US with ready=0 goes to S_DONE with err=1.
- S_DONE (1 cycle): ack=1, err valid, busy=1. Then go to S_IDLE.
- busy=1 in every state except S_IDLE. cs is ignored while busy. A new request is accepted no earlier than the first S_IDLE cycle after ack.
- wp_n=1 only in S_SETUP, S_PULSE, S_HOLD, and S_BUSY.

## Timing
- All outputs are registered (next-state decoded); no combinational paths from inputs to pins.
- One bus cycle = 1 + COUNT_WP + COUNT_WPH = 11 clk at 100 MHz.
- RESET: ack is high in the 12th cycle after the accepting edge.
- PROGRAM: first ack ≥ 44 + 51 + 1 cycles after acceptance; ack follows the first sampled ready=1 by one cycle.
- Erase: 66 bus-cycle clocks, then busy wait.
- Timeout resolution: 1 µs; error asserted within TIMEOUT_US + 1 µs after S_BUSY entry.

## Structure
- Shared package/header holds:
  - op encodings;
  - command constants (555, 2AA, AA, 55, A0, 80, 30, 10, F0);
  - DELAY_* values;
  - GET_WIDTH for counter widths.
- Sub-module flash_cmd_rom is combinational: (op, index) → (addr, data, last). The FSM, counters, and prescaler stay in flash_prog_core.

## Test plan
- Reset release, ready=1 → all pins idle; flash_rst_n=1 one cycle later; busy=1 for 30001 cycles, then 0.
- RESET op, addr=0x000010 → one we_n low pulse exactly 6 cycles with flash_dout=0x00F0 and flash_addr=0x000010; ack=1 and err=0 in cycle 12; oe_n stays 1.
- PROGRAM addr=0x123456 din=0xBEEF; model drops ready 10 cycles after the 4th pulse and holds it low 200 cycles → four pulses (555,AA) (2AA,55) (555,A0) (123456,BEEF); ack one cycle after ready rises; err=0.
- SECTOR_ERASE with TIMEOUT_US=10 and ready held low → six correct pulses; ack with err=1 at 10–11 µs after S_BUSY entry.
- CHIP_ERASE with ready never dropping → ready ignored for 51 cycles, then ack on the next cycle; last entry (555,0010).
- rst_n asserted during a we_n-low cycle → we_n, ce_n, wp_n go inactive and flash_rst_n=0 without waiting for clk; after release, S_INIT is re-entered and a subsequent PROGRAM completes normally.

Source files
------------

// File: rtl/flash_prog_pkg.sv
// Shared definitions for the NOR flash program/erase core: operation codes,
// FSM states, AMD/CFI command words, write-cycle delays and sizing helpers.
package flash_prog_pkg;

   typedef enum logic [1:0] {
      OP_RESET        = 2'd0,
      OP_PROGRAM      = 2'd1,
      OP_SECTOR_ERASE = 2'd2,
      OP_CHIP_ERASE   = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_BUSY, S_DONE
   } state_e;

   // Unlock/command addresses (word addresses) and command data words
   localparam logic [15:0] CMD_ADDR_555 = 16'h0555;
   localparam logic [15:0] CMD_ADDR_2AA = 16'h02AA;
   localparam logic [15:0] CMD_AA       = 16'h00AA;
   localparam logic [15:0] CMD_55       = 16'h0055;
   localparam logic [15:0] CMD_A0       = 16'h00A0;
   localparam logic [15:0] CMD_80       = 16'h0080;
   localparam logic [15:0] CMD_30       = 16'h0030;
   localparam logic [15:0] CMD_10       = 16'h0010;
   localparam logic [15:0] CMD_F0       = 16'h00F0;

   // Delays in ns: power-up/reset recovery, WE# low, WE# high, RY/BY# valid
   localparam int DELAY_INIT = 300000;
   localparam int DELAY_WP   = 50;
   localparam int DELAY_WPH  = 30;
   localparam int DELAY_BUSY = 500;

   // Number of bits needed to hold the value itself
   function automatic int GET_WIDTH(input int unsigned value);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++)
         if ((value >> i) != 0) w = i + 1;
      return w;
   endfunction

   // Cycle count for a delay, rounded up by one clock
   function automatic int COUNT_OF(input int clk_mhz, input int delay_ns);
      return 1 + clk_mhz * delay_ns / 1000;
   endfunction

endpackage

// File: rtl/flash_cmd_rom.sv
// Command sequence table: maps (operation, step index) to the bus-cycle
// address/data pair and flags the final step of the sequence.
module flash_cmd_rom
   import flash_prog_pkg::*;
#(
   parameter int AW = 23
) (
   input  logic [1:0]    op,
   input  logic [2:0]    idx,
   input  logic [AW-1:0] usr_addr,
   input  logic [15:0]   usr_din,
   output logic [AW-1:0] cmd_addr,
   output logic [15:0]   cmd_data,
   output logic          last
);

   // Table lookup; erase sequences share the first five unlock/setup steps
   always_comb begin
      cmd_addr = '0;
      cmd_data = '0;
      last     = 1'b1;
      case (op)
         OP_RESET: begin
            cmd_addr = usr_addr;
            cmd_data = CMD_F0;
         end
         OP_PROGRAM: begin
            last = 1'b0;
            case (idx)
               3'd0:    begin cmd_addr = AW'(CMD_ADDR_555); cmd_data = CMD_AA; end
               3'd1:    begin cmd_addr = AW'(CMD_ADDR_2AA); cmd_data = CMD_55; end
               3'd2:    begin cmd_addr = AW'(CMD_ADDR_555); cmd_data = CMD_A0; end
               default: begin cmd_addr = usr_addr; cmd_data = usr_din; last = 1'b1; end
            endcase
         end
         default: begin
            last = 1'b0;
            case (idx)
               3'd0:    begin cmd_addr = AW'(CMD_ADDR_555); cmd_data = CMD_AA; end
               3'd1:    begin cmd_addr = AW'(CMD_ADDR_2AA); cmd_data = CMD_55; end
               3'd2:    begin cmd_addr = AW'(CMD_ADDR_555); cmd_data = CMD_80; end
               3'd3:    begin cmd_addr = AW'(CMD_ADDR_555); cmd_data = CMD_AA; end
               3'd4:    begin cmd_addr = AW'(CMD_ADDR_2AA); cmd_data = CMD_55; end
               default: begin
                  last = 1'b1;
                  if (op == OP_SECTOR_ERASE) begin
                     cmd_addr = usr_addr;
                     cmd_data = CMD_30;
                  end else begin
                     cmd_addr = AW'(CMD_ADDR_555);
                     cmd_data = CMD_10;
                  end
               end
            endcase
         end
      endcase
   end

endmodule

// File: rtl/flash_prog_core.sv
// NOR flash write-side core: runs WE#-controlled command sequences for
// program/erase/reset and waits on RY/BY# with a microsecond timeout.
// All pin outputs are registered from next-state decode.
module flash_prog_core
   import flash_prog_pkg::*;
#(
   parameter int CLK_FREQ   = 100,
   parameter int ADDR_BITS  = 24,
   parameter int TIMEOUT_US = 4000000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cs,
   input  logic [1:0]           op,
   input  logic [ADDR_BITS-2:0] addr,
   input  logic [15:0]          din,
   output logic                 busy,
   output logic                 ack,
   output logic                 err,
   output logic                 flash_ce_n,
   output logic                 flash_oe_n,
   output logic                 flash_we_n,
   output logic                 flash_wp_n,
   output logic                 flash_rst_n,
   input  logic                 flash_ready,
   output logic [ADDR_BITS-2:0] flash_addr,
   input  logic [15:0]          flash_din,
   output logic [15:0]          flash_dout
);

   localparam int AW         = ADDR_BITS - 1;
   localparam int COUNT_INIT = COUNT_OF(CLK_FREQ, DELAY_INIT);
   localparam int COUNT_WP   = COUNT_OF(CLK_FREQ, DELAY_WP);
   localparam int COUNT_WPH  = COUNT_OF(CLK_FREQ, DELAY_WPH);
   localparam int COUNT_BUSY = COUNT_OF(CLK_FREQ, DELAY_BUSY);
   localparam int CNT_W      = GET_WIDTH(COUNT_INIT);
   localparam int PRE_W      = GET_WIDTH(CLK_FREQ);
   localparam int US_W       = GET_WIDTH(TIMEOUT_US);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(COUNT_INIT - 1);
   localparam logic [CNT_W-1:0] WP_LAST   = CNT_W'(COUNT_WP - 1);
   localparam logic [CNT_W-1:0] WPH_LAST  = CNT_W'(COUNT_WPH - 1);
   localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(COUNT_BUSY - 1);
   localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_FREQ - 1);
   localparam logic [US_W-1:0]  US_ONE    = US_W'(1);
   localparam logic [US_W-1:0]  US_LIMIT  = US_W'(TIMEOUT_US);

   state_e           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [PRE_W-1:0] pre, pre_nx;
   logic [US_W-1:0]  us_cnt, us_nx;
   logic [2:0]       idx_r, idx_nx;
   logic             last_r, last_nx;
   logic             ld_req;
   logic [1:0]       op_r;
   logic [AW-1:0]    addr_r;
   logic [15:0]      din_r;
   logic             ce_nx, we_nx, wp_nx, busy_nx, ack_nx, err_nx;
   logic [AW-1:0]    addr_nx;
   logic [15:0]      dout_nx;

   logic             sel_idle;
   logic [1:0]       rom_op;
   logic [2:0]       rom_idx;
   logic [AW-1:0]    rom_usr_addr, rom_addr;
   logic [15:0]      rom_usr_din, rom_data;
   logic             rom_last;

   // Status read-back is reserved; the data bus is not consumed yet
   logic unused_flash_din;
   assign unused_flash_din = ^flash_din;

   // The table is looked up one step ahead: the request itself while idle,
   // otherwise the step after the current one, so pins load on the edge
   // that enters S_SETUP.
   assign sel_idle     = (state == S_IDLE);
   assign rom_op       = sel_idle ? op   : op_r;
   assign rom_idx      = sel_idle ? 3'd0 : idx_r + 3'd1;
   assign rom_usr_addr = sel_idle ? addr : addr_r;
   assign rom_usr_din  = sel_idle ? din  : din_r;

   flash_cmd_rom #(.AW(AW)) u_rom (
      .op       (rom_op),
      .idx      (rom_idx),
      .usr_addr (rom_usr_addr),
      .usr_din  (rom_usr_din),
      .cmd_addr (rom_addr),
      .cmd_data (rom_data),
      .last     (rom_last)
   );

   // Next state, counters and next pin values
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pre_nx   = pre;
      us_nx    = us_cnt;
      idx_nx   = idx_r;
      last_nx  = last_r;
      ld_req   = 1'b0;
      ce_nx    = 1'b1;
      we_nx    = 1'b1;
      wp_nx    = 1'b0;
      busy_nx  = 1'b1;
      ack_nx   = 1'b0;
      err_nx   = 1'b0;
      addr_nx  = flash_addr;
      dout_nx  = flash_dout;
      case (state)
         S_INIT: begin
            // recovery time counts from the flash's own reset release
            if (flash_rst_n) begin
               if (cnt != INIT_LAST) begin
                  cnt_nx = cnt + CNT_ONE;
               end else if (flash_ready) begin
                  state_nx = S_IDLE;
                  cnt_nx   = '0;
                  busy_nx  = 1'b0;
               end
            end
         end
         S_IDLE: begin
            busy_nx = 1'b0;
            if (cs) begin
               state_nx = S_SETUP;
               ld_req   = 1'b1;
               idx_nx   = 3'd0;
               last_nx  = rom_last;
               addr_nx  = rom_addr;
               dout_nx  = rom_data;
               ce_nx    = 1'b0;
               wp_nx    = 1'b1;
               busy_nx  = 1'b1;
            end
         end
         S_SETUP: begin
            state_nx = S_PULSE;
            cnt_nx   = '0;
            ce_nx    = 1'b0;
            we_nx    = 1'b0;
            wp_nx    = 1'b1;
         end
         S_PULSE: begin
            wp_nx = 1'b1;
            if (cnt == WP_LAST) begin
               state_nx = S_HOLD;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_ONE;
               ce_nx  = 1'b0;
               we_nx  = 1'b0;
            end
         end
         S_HOLD: begin
            wp_nx = 1'b1;
            if (cnt != WPH_LAST) begin
               cnt_nx = cnt + CNT_ONE;
            end else begin
               cnt_nx = '0;
               if (!last_r) begin
                  state_nx = S_SETUP;
                  idx_nx   = idx_r + 3'd1;
                  last_nx  = rom_last;
                  addr_nx  = rom_addr;
                  dout_nx  = rom_data;
                  ce_nx    = 1'b0;
               end else if (op_r == OP_RESET) begin
                  state_nx = S_DONE;
                  wp_nx    = 1'b0;
                  ack_nx   = 1'b1;
               end else begin
                  state_nx = S_BUSY;
                  pre_nx   = '0;
                  us_nx    = '0;
               end
            end
         end
         S_BUSY: begin
            wp_nx = 1'b1;
            if (cnt != BUSY_LAST) cnt_nx = cnt + CNT_ONE;
            if (pre == PRE_LAST) begin
               pre_nx = '0;
               us_nx  = us_cnt + US_ONE;
            end else begin
               pre_nx = pre + PRE_ONE;
            end
            // RY/BY# is only trusted once tBUSY has elapsed
            if (cnt == BUSY_LAST && flash_ready) begin
               state_nx = S_DONE;
               wp_nx    = 1'b0;
               ack_nx   = 1'b1;
            end else if (us_cnt == US_LIMIT) begin
               state_nx = S_DONE;
               wp_nx    = 1'b0;
               ack_nx   = 1'b1;
               err_nx   = 1'b1;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
            busy_nx  = 1'b0;
         end
         default: state_nx = S_INIT;
      endcase
   end

   // Control state and registered pins; reset also holds the flash in reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_INIT;
         cnt         <= '0;
         pre         <= '0;
         us_cnt      <= '0;
         idx_r       <= '0;
         last_r      <= 1'b0;
         flash_ce_n  <= 1'b1;
         flash_oe_n  <= 1'b1;
         flash_we_n  <= 1'b1;
         flash_wp_n  <= 1'b0;
         flash_rst_n <= 1'b0;
         flash_addr  <= '0;
         flash_dout  <= '0;
         busy        <= 1'b0;
         ack         <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         pre         <= pre_nx;
         us_cnt      <= us_nx;
         idx_r       <= idx_nx;
         last_r      <= last_nx;
         flash_ce_n  <= ce_nx;
         flash_oe_n  <= 1'b1;
         flash_we_n  <= we_nx;
         flash_wp_n  <= wp_nx;
         flash_rst_n <= 1'b1;
         flash_addr  <= addr_nx;
         flash_dout  <= dout_nx;
         busy        <= busy_nx;
         ack         <= ack_nx;
         err         <= err_nx;
      end
   end

   // Request capture; pure data, only meaningful after a request is taken
   always_ff @(posedge clk) begin
      if (ld_req) begin
         op_r   <= op;
         addr_r <= addr;
         din_r  <= din;
      end
   end

endmodule
